sum_serial: RTL and testbench

//   Parametrised multi-cycle adder: WIDTH-bit operands added DIGIT bits per clock through a carry-registered adder slice.

---
 rtl/sum_serial.sv | 116 +++++++++++
 tb/tb_sum_serial.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_serial.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock with a registered carry.
// Define SUM_SERIAL_SUB_EN to add the 'op' port (op=1 computes xi - yi).
module sum_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] yi,
  input  logic             ci,
`ifdef SUM_SERIAL_SUB_EN
  input  logic             op,
`endif
  output logic [WIDTH-1:0] Si,
  output logic             Co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // RUN   | one digit added per edge, N edges in total
  // DONE  | one-cycle result-valid pulse

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("sum_serial: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_sh, y_sh, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic [WIDTH-1:0] y_ld;
  logic             c_ld;

`ifdef SUM_SERIAL_SUB_EN
  // subtract as x + ~y + 1; Co then reads as "no borrow"
  assign y_ld = op ? ~yi : yi;
  assign c_ld = op ? 1'b1 : ci;
`else
  assign y_ld = yi;
  assign c_ld = ci;
`endif

  always_comb begin
    dsum    = {1'b0, x_sh[DIGIT-1:0]} + {1'b0, y_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    res_nxt = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // carry into the digit's top bit, recovered from its sum bit; on the last digit this is the MSB carry-in
    msb_cin = dsum[DIGIT-1] ^ x_sh[DIGIT-1] ^ y_sh[DIGIT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh  <= '0;
      y_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Si    <= '0;
      Co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      x_sh  <= xi;
      y_sh  <= y_ld;
      carry <= c_ld;
      res   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      x_sh  <= x_sh >> DIGIT;
      y_sh  <= y_sh >> DIGIT;
      carry <= dsum[DIGIT];
      res   <= res_nxt;
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        Si  <= res_nxt;
        Co  <= dsum[DIGIT];
        ovf <= msb_cin ^ dsum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_sum_serial.sv
// Bench for sum_serial: DIGIT=1 and DIGIT=4 instances checked every cycle against an arithmetic model.
// Honours SUM_SERIAL_SUB_EN when defined at compile time.
module tb_sum_serial;
  localparam int W  = 8;
  localparam int NI = 2;
`ifdef SUM_SERIAL_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   start = '0;
  logic [W-1:0] xi = '0, yi = '0;
  logic         ci = 1'b0, op = 1'b0;
  logic [W-1:0] si [2];
  logic [1:0]   co, ovf_o, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sum_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[0]), .xi(xi), .yi(yi), .ci(ci),
`ifdef SUM_SERIAL_SUB_EN
    .op(op),
`endif
    .Si(si[0]), .Co(co[0]), .ovf(ovf_o[0]), .busy(busy[0]), .done(done[0]));

  sum_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start[1]), .xi(xi), .yi(yi), .ci(ci),
`ifdef SUM_SERIAL_SUB_EN
    .op(op),
`endif
    .Si(si[1]), .Co(co[1]), .ovf(ovf_o[1]), .busy(busy[1]), .done(done[1]));

  function automatic int n_of(input int i);
    return (i == 0) ? W : W / 4;
  endfunction

  // returns {ovf, Co, Si} from plain integer arithmetic
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic o);
    logic [W-1:0] yb;
    int u, sx, sy, sr;
    logic co_e, ov;
    yb   = o ? ~y : y;
    u    = int'(x) + int'(yb) + (o ? 1 : int'(c));
    co_e = (u >= (1 << W));
    sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
    sr   = o ? (sx - sy) : (sx + sy + int'(c));
    ov   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {ov, co_e, u[W-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // model: k = edges since the accepting edge; idle once k > N
  int           k [2] = '{W + 1, W / 4 + 1};
  logic [W+1:0] e_out [2] = '{default: '0};
  logic [W+1:0] p_out [2] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        k[i]     = n_of(i) + 1;
        e_out[i] = '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (k[i] > n_of(i)) begin
          if (start[i]) begin
            k[i]     = 0;
            p_out[i] = ref_add(xi, yi, ci, SUB ? op : 1'b0);
          end
        end else begin
          k[i]++;
          if (k[i] == n_of(i)) e_out[i] = p_out[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(k[i] < n_of(i)));
        chk($sformatf("done%0d", i), 32'(done[i]), 32'(k[i] == n_of(i)));
        chk($sformatf("Si%0d", i),   32'(si[i]),   32'(e_out[i][W-1:0]));
        chk($sformatf("Co%0d", i),   32'(co[i]),   32'(e_out[i][W]));
        chk($sformatf("ovf%0d", i),  32'(ovf_o[i]), 32'(e_out[i][W+1]));
      end
    end
  end

  task automatic wait_idle(input int i);
    bit got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(posedge clk); #1;
      if (!busy[i] && !done[i]) got = 1'b1;
    end
    if (!got) timeout_fail("idle_wait");
  endtask

  // disturb: RUN cycle at which a competing start with other operands is raised (0 = none)
  task automatic run_op(input string nm, input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic o, input logic [W+1:0] want, input int disturb);
    int cyc = 0, bcnt = 0;
    bit got = 1'b0;
    wait_idle(i);
    xi = x; yi = y; ci = c; op = o; start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    @(negedge clk);
    if (busy[i]) bcnt++;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == disturb) begin
        start[i] = 1'b1; xi = ~x; yi = 8'h5A; ci = ~c; op = 1'b0;
      end else start[i] = 1'b0;
      @(negedge clk);
      if (done[i]) got = 1'b1;
      else if (busy[i]) bcnt++;
    end
    start[i] = 1'b0;
    if (!got) timeout_fail({nm, "_done"});
    else begin
      chk({nm, "_latency"}, 32'(cyc), 32'(n_of(i)));
      chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(n_of(i)));
      chk({nm, "_Si"},  32'(si[i]),    32'(want[W-1:0]));
      chk({nm, "_Co"},  32'(co[i]),    32'(want[W]));
      chk({nm, "_ovf"}, 32'(ovf_o[i]), 32'(want[W+1]));
    end
  endtask

  task automatic reset_mid(input int i);
    int dcnt = 0;
    wait_idle(i);
    xi = 8'h12; yi = 8'h34; ci = 1'b0; op = 1'b0; start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_Si",   32'(si[i]),    32'h0);
    chk("rst_Co",   32'(co[i]),    32'h0);
    chk("rst_ovf",  32'(ovf_o[i]), 32'h0);
    chk("rst_busy", 32'(busy[i]),  32'h0);
    chk("rst_done", 32'(done[i]),  32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3 * n_of(i)) begin
      @(negedge clk);
      if (done[i]) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'h0);
  endtask

  initial begin
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("ref_3c_0f", 32'(ref_add(8'h3C, 8'h0F, 1'b0, 1'b0)), 32'({1'b0, 1'b0, 8'h4B}));
    chk("ref_ff_01", 32'(ref_add(8'hFF, 8'h01, 1'b0, 1'b0)), 32'({1'b0, 1'b1, 8'h00}));
    chk("ref_7f_00", 32'(ref_add(8'h7F, 8'h00, 1'b1, 1'b0)), 32'({1'b1, 1'b0, 8'h80}));
    chk("ref_80_80", 32'(ref_add(8'h80, 8'h80, 1'b0, 1'b0)), 32'({1'b1, 1'b1, 8'h00}));
    chk("ref_05_07", 32'(ref_add(8'h05, 8'h07, 1'b0, 1'b1)), 32'({1'b0, 1'b0, 8'hFE}));

    run_op("add_3c_0f", 0, 8'h3C, 8'h0F, 1'b0, 1'b0, {1'b0, 1'b0, 8'h4B}, 0);
    run_op("add_ff_01", 0, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, 0);
    run_op("add_7f_00", 0, 8'h7F, 8'h00, 1'b1, 1'b0, {1'b1, 1'b0, 8'h80}, 0);
    run_op("add_80_80", 0, 8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00}, 0);
    run_op("ignore_start", 0, 8'h3C, 8'h0F, 1'b0, 1'b0, {1'b0, 1'b0, 8'h4B}, 3);
    reset_mid(0);
    run_op("after_rst", 0, 8'h3C, 8'h0F, 1'b0, 1'b0, {1'b0, 1'b0, 8'h4B}, 0);
    run_op("d4_9a_66", 1, 8'h9A, 8'h66, 1'b1, 1'b0, {1'b0, 1'b1, 8'h01}, 0);
    run_op("d4_7f_01", 1, 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}, 0);
`ifdef SUM_SERIAL_SUB_EN
    run_op("d4_sub_05_07", 1, 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE}, 0);
    run_op("d1_sub_05_07", 0, 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, 0);
    run_op("d1_sub_80_01", 0, 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}, 0);
`endif

    repeat (3000) begin
      @(posedge clk); #1;
      start[0] = ($urandom_range(0, 2) == 0);
      start[1] = ($urandom_range(0, 2) == 0);
      xi  = 8'($urandom);
      yi  = 8'($urandom);
      ci  = 1'($urandom);
      op  = SUB ? 1'($urandom) : 1'b0;
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    start = '0;
    rst   = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
